pb_io_bridge: RTL and testbench
===============================

// Module: pb_io_bridge
// PURPOSE
//  Parametrised PicoBlaze (kcpsm3) I/O bridge: decodes port_id into channel, status, output and scratch-RAM windows.
//  Per-channel input FIFOs with valid/ready decouple producers (e.g. a keystream core) from the consumer core.
//  Presents one registered in_port and a masked interrupt with ack.
//  Replaces ad-hoc mux + RAM glue between cipher cores.
// PARAMETERS
//  NUM_CH      4   input/output channel count, 1..8
//  FIFO_DEPTH  4   entries per input FIFO, power of 2, 2..16
//  RAM_DEPTH   32  scratch RAM bytes, power of 2, 2..128
// PORTS
//  clk            in   1           rising-edge clock
//  reset_n        in   1           asynchronous, active-low reset
//  port_id        in   8           from core
//  out_port       in   8           from core
//  write_strobe   in   1           from core
//  read_strobe    in   1           from core
//  in_port        out  8           to core, registered
//  interrupt      out  1           to core
//  interrupt_ack  in   1           from core
//  ch_in_valid    in   NUM_CH      producer valid, one bit per channel
//  ch_in_data     in   8*NUM_CH    producer data; channel c at [8c+7:8c]
//  ch_in_ready    out  NUM_CH      = !full[c], combinational
//  ch_out_valid   out  NUM_CH      one-cycle pulse per core write
//  ch_out_data    out  8*NUM_CH    last value written; held
// BEHAVIOUR
//  Address map; c = port_id[2:0], a = port_id[6:0] mod RAM_DEPTH:
//    1xxxxxxx  RAM[a]; R/W.
//    00000ccc  read: FIFO c head (0x00 if empty); read_strobe pops.
//    01000ccc  read: status c = {count[4:0], underflow, full, empty}; any write clears underflow c.
//    10000ccc  write: ch_out_data[c] <= out_port; ch_out_valid[c] = 1 for the next cycle.
//    11000000  R/W: irq_mask[NUM_CH-1:0]; upper bits read 0.
//    Other ports, or c >= NUM_CH: reads 0x00, writes ignored.
//  in_port <= mux(port_id) every cycle, independent of read_strobe.
//    Latency 1: valid on the edge after port_id settles (kcpsm3 holds port_id 2 cycles).
//  RAM: combinational read, write on write_strobe; contents not reset.
//  FIFO c push: ch_in_valid[c] & ch_in_ready[c].
//    Full: ready=0, push dropped, even if a pop occurs the same cycle.
//    Simultaneous push and pop when not full or empty: count unchanged, order preserved.
//    Pop on empty: no pointer change; sets sticky underflow[c].
//  Pointers wrap modulo FIFO_DEPTH; count is 0..FIFO_DEPTH.
//  IRQ: pending set when any FIFO c with irq_mask[c]=1 goes empty->non-empty.
//    interrupt = pending, registered.
//    interrupt_ack clears pending; a set in the same cycle wins.
//  Reset values:
//    in_port=0, interrupt=0, ch_out_valid=0, ch_out_data=0, irq_mask=0.
//    All FIFOs empty (ready=1), underflow=0.
//  Reset mid-operation discards FIFO contents immediately (async).
// STRUCTURE
//  pb_io_pkg: window codes (2'b00/01/10/11), status bit positions, clog2 function.
//  Sub-module pb_chan_fifo (WIDTH=8, DEPTH): push/pop/empty/full/count/underflow.
//    Instantiated NUM_CH times in a generate loop.
//  Top holds decode, RAM array, in_port register, out regs, IRQ logic.
// TESTING (NUM_CH=4, FIFO_DEPTH=4, RAM_DEPTH=32)
//  1 Reset release -> all outputs 0, ch_in_ready=4'hF; read port 0x40 -> in_port 0x01.
//  2 Push A5,3C,7E on ch1; three reads of 0x01 with read_strobe -> A5,3C,7E; then 0x41 -> 0x01.
//  3 Push 5 bytes on ch0 -> ready[0]=0 after 4th, 5th dropped; 0x40 -> 0x22; pops return first 4.
//  4 Pop empty ch2 -> in_port 0x00, 0x42 -> 0x05; write 0x42 -> 0x01.
//  5 Write 9C to 0x85, 11 to 0x80 -> read 0x85=9C, 0xA5 aliases to 9C.
//  5b Write 77 to 0x83 -> ch_out_valid=4'b1000 for 1 cycle, ch_out_data[31:24]=77.
//  6 Mask 0x02; push ch0 -> interrupt stays 0; push ch1 -> interrupt 1; ack -> 0.
//  6b Assert reset_n=0 while ch0 full -> empty, ready 1, interrupt 0.

Source files
------------

// File: rtl/pb_io_pkg.sv
// Shared definitions for the PicoBlaze I/O bridge: address windows, status
// byte layout and a constant-width helper.
package pb_io_pkg;

  typedef enum logic [1:0] {
    WIN_FIFO = 2'b00,
    WIN_STAT = 2'b01,
    WIN_OUT  = 2'b10,
    WIN_CTRL = 2'b11
  } win_e;

  localparam logic [7:0] MASK_PORT = 8'hC0;

  // Status byte: {count[4:0], underflow, full, empty}
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_UNDERFLOW = 2;
  localparam int ST_COUNT_LSB = 3;
  localparam int CNT_W        = 5;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pb_chan_fifo.sv
// Small first-word-fall-through FIFO for one producer channel, with a sticky
// underflow flag raised by popping while empty.
module pb_chan_fifo
  import pb_io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clr_uf,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             underflow
);

  localparam int AW = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             uf_reg;
  logic             push_ok;
  logic             pop_ok;

  assign empty     = (count_reg == '0);
  assign full      = (count_reg == CNT_W'(DEPTH));
  assign count     = count_reg;
  assign underflow = uf_reg;
  assign dout      = mem[rd_ptr_reg];

  // A push into a full FIFO is dropped even when a pop frees a slot that cycle.
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      uf_reg     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (!push_ok && pop_ok) count_reg <= count_reg - 1'b1;
      if (pop && empty) uf_reg <= 1'b1;
      else if (clr_uf)  uf_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

endmodule

// File: rtl/pb_io_bridge.sv
// PicoBlaze port decoder: channel FIFOs, status, channel outputs, scratch RAM
// and a maskable "FIFO became non-empty" interrupt behind one registered in_port.
module pb_io_bridge
  import pb_io_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int RAM_DEPTH  = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [7:0]          port_id,
  input  logic [7:0]          out_port,
  input  logic                write_strobe,
  input  logic                read_strobe,
  output logic [7:0]          in_port,
  output logic                interrupt,
  input  logic                interrupt_ack,
  input  logic [NUM_CH-1:0]   ch_in_valid,
  input  logic [8*NUM_CH-1:0] ch_in_data,
  output logic [NUM_CH-1:0]   ch_in_ready,
  output logic [NUM_CH-1:0]   ch_out_valid,
  output logic [8*NUM_CH-1:0] ch_out_data
);

  localparam int RAM_AW = (clog2(RAM_DEPTH) < 1) ? 1 : clog2(RAM_DEPTH);

  win_e              win;
  logic [2:0]        ch_sel;
  logic              sub_zero;
  logic              is_fifo;
  logic              is_stat;
  logic              is_out;
  logic              is_mask;
  logic              is_ram;
  logic [RAM_AW-1:0] ram_addr;

  logic [7:0]        ram_mem [RAM_DEPTH];
  logic [7:0]        rd_data;
  logic [7:0]        in_port_reg;
  logic [NUM_CH-1:0] irq_mask_reg;
  logic              irq_pending_reg;
  logic              irq_set;
  logic [NUM_CH-1:0] ch_out_valid_reg;
  logic [7:0]        ch_out_data_reg [NUM_CH];

  logic [NUM_CH-1:0] pop_req;
  logic [NUM_CH-1:0] clr_uf;
  logic [NUM_CH-1:0] out_we;
  logic [NUM_CH-1:0] fifo_empty;
  logic [NUM_CH-1:0] fifo_full;
  logic [NUM_CH-1:0] fifo_uf;
  logic [7:0]        fifo_dout  [NUM_CH];
  logic [CNT_W-1:0]  fifo_count [NUM_CH];

  // Padded to the full 3-bit channel field so absent channels read as zero.
  logic [7:0]        head_all [8];
  logic [7:0]        stat_all [8];

  assign win      = win_e'(port_id[7:6]);
  assign ch_sel   = port_id[2:0];
  assign sub_zero = (port_id[5:3] == 3'b000);
  assign is_fifo  = (win == WIN_FIFO) && sub_zero;
  assign is_stat  = (win == WIN_STAT) && sub_zero;
  assign is_out   = (win == WIN_OUT) && sub_zero;
  assign is_mask  = (port_id == MASK_PORT);
  // 0x80-0x87 are write-through: RAM and channel output both update; the mask port shadows RAM.
  assign is_ram   = port_id[7] && !is_mask;
  assign ram_addr = port_id[RAM_AW-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign pop_req[gi] = read_strobe  & is_fifo & (ch_sel == 3'(gi));
      assign clr_uf[gi]  = write_strobe & is_stat & (ch_sel == 3'(gi));
      assign out_we[gi]  = write_strobe & is_out  & (ch_sel == 3'(gi));

      pb_chan_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ch_in_valid[gi]),
        .pop       (pop_req[gi]),
        .clr_uf    (clr_uf[gi]),
        .din       (ch_in_data[8*gi +: 8]),
        .dout      (fifo_dout[gi]),
        .empty     (fifo_empty[gi]),
        .full      (fifo_full[gi]),
        .count     (fifo_count[gi]),
        .underflow (fifo_uf[gi])
      );

      assign ch_out_data[8*gi +: 8] = ch_out_data_reg[gi];
    end

    for (gi = 0; gi < 8; gi++) begin : g_pad
      if (gi < NUM_CH) begin : g_live
        assign head_all[gi] = fifo_empty[gi] ? 8'h00 : fifo_dout[gi];
        assign stat_all[gi] = ({3'b000, fifo_count[gi]} << ST_COUNT_LSB)
                            | ({7'b0, fifo_uf[gi]}    << ST_UNDERFLOW)
                            | ({7'b0, fifo_full[gi]}  << ST_FULL)
                            | ({7'b0, fifo_empty[gi]} << ST_EMPTY);
      end else begin : g_none
        assign head_all[gi] = 8'h00;
        assign stat_all[gi] = 8'h00;
      end
    end
  endgenerate

  assign ch_in_ready  = ~fifo_full;
  assign ch_out_valid = ch_out_valid_reg;
  assign in_port      = in_port_reg;
  assign interrupt    = irq_pending_reg;

  always_comb begin
    rd_data = 8'h00;
    if (is_mask)      rd_data[NUM_CH-1:0] = irq_mask_reg;
    else if (is_ram)  rd_data = ram_mem[ram_addr];
    else if (is_fifo) rd_data = head_all[ch_sel];
    else if (is_stat) rd_data = stat_all[ch_sel];
  end

  // An accepted push into an empty FIFO is exactly the empty->non-empty transition.
  assign irq_set = |(irq_mask_reg & fifo_empty & ch_in_valid & ch_in_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_port_reg      <= 8'h00;
      irq_mask_reg     <= '0;
      irq_pending_reg  <= 1'b0;
      ch_out_valid_reg <= '0;
      for (int i = 0; i < NUM_CH; i++) ch_out_data_reg[i] <= 8'h00;
    end else begin
      in_port_reg      <= rd_data;
      ch_out_valid_reg <= out_we;
      for (int i = 0; i < NUM_CH; i++) begin
        if (out_we[i]) ch_out_data_reg[i] <= out_port;
      end
      if (write_strobe && is_mask) irq_mask_reg <= out_port[NUM_CH-1:0];
      if (irq_set)            irq_pending_reg <= 1'b1;
      else if (interrupt_ack) irq_pending_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (write_strobe && is_ram) ram_mem[ram_addr] <= out_port;
  end

endmodule

// File: tb/tb_pb_io_bridge.sv
// Directed plus randomized checks of pb_io_bridge against a queue-style
// reference model of the port map, FIFOs, RAM and interrupt.
module tb_pb_io_bridge;

  logic        clk;
  logic        reset_n;
  logic [7:0]  port_id;
  logic [7:0]  out_port;
  logic        write_strobe;
  logic        read_strobe;
  logic [7:0]  in_port;
  logic        interrupt;
  logic        interrupt_ack;
  logic [3:0]  ch_in_valid;
  logic [31:0] ch_in_data;
  logic [3:0]  ch_in_ready;
  logic [3:0]  ch_out_valid;
  logic [31:0] ch_out_data;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] qm [4][4];
  int         qn [4];
  bit         uf_m [4];
  logic [3:0] mask_m;
  bit         pend_m;
  logic [7:0] ram_m [32];
  bit         ram_known [32];
  logic [7:0] od_m [4];
  logic [3:0] ov_m;

  pb_io_bridge #(
    .NUM_CH     (4),
    .FIFO_DEPTH (4),
    .RAM_DEPTH  (32)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .port_id       (port_id),
    .out_port      (out_port),
    .write_strobe  (write_strobe),
    .read_strobe   (read_strobe),
    .in_port       (in_port),
    .interrupt     (interrupt),
    .interrupt_ack (interrupt_ack),
    .ch_in_valid   (ch_in_valid),
    .ch_in_data    (ch_in_data),
    .ch_in_ready   (ch_in_ready),
    .ch_out_valid  (ch_out_valid),
    .ch_out_data   (ch_out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      qn[c]   = 0;
      uf_m[c] = 1'b0;
      od_m[c] = 8'h00;
    end
    mask_m = 4'h0;
    pend_m = 1'b0;
    ov_m   = 4'h0;
  endtask

  // Returns {known, byte} for what a read of port p should present.
  function automatic logic [8:0] model_read(input logic [7:0] p);
    int c;
    c = int'(p[2:0]);
    if (p == 8'hC0) return {1'b1, 4'h0, mask_m};
    if (p[7]) return {ram_known[p[4:0]], ram_m[p[4:0]]};
    if (p[7:3] == 5'b00000 && c < 4) return {1'b1, (qn[c] > 0) ? qm[c][0] : 8'h00};
    if (p[7:3] == 5'b01000 && c < 4)
      return {1'b1, 5'(qn[c]), uf_m[c], qn[c] == 4, qn[c] == 0};
    return {1'b1, 8'h00};
  endfunction

  // One clock: predict from current inputs, advance the model, then compare.
  task automatic tick();
    logic [8:0] rd;
    bit         irq_set;
    logic [3:0] ready_m;
    rd      = model_read(port_id);
    irq_set = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bit accept;
      bit was_empty;
      accept    = ch_in_valid[c] && (qn[c] < 4);
      was_empty = (qn[c] == 0);
      if (read_strobe && port_id == 8'(c)) begin
        if (qn[c] > 0) begin
          for (int k = 0; k < 3; k++) qm[c][k] = qm[c][k+1];
          qn[c]--;
        end else begin
          uf_m[c] = 1'b1;
        end
      end
      if (accept) begin
        qm[c][qn[c]] = ch_in_data[8*c +: 8];
        qn[c]++;
      end
      if (accept && was_empty && mask_m[c]) irq_set = 1'b1;
    end
    ov_m = 4'h0;
    if (write_strobe) begin
      if (port_id == 8'hC0) mask_m = out_port[3:0];
      else if (port_id[7]) begin
        ram_m[port_id[4:0]]     = out_port;
        ram_known[port_id[4:0]] = 1'b1;
      end
      if (port_id >= 8'h80 && port_id <= 8'h83) begin
        od_m[port_id[1:0]] = out_port;
        ov_m[port_id[1:0]] = 1'b1;
      end
      if (port_id >= 8'h40 && port_id <= 8'h43) uf_m[port_id[1:0]] = 1'b0;
    end
    if (irq_set) pend_m = 1'b1;
    else if (interrupt_ack) pend_m = 1'b0;
    for (int c = 0; c < 4; c++) ready_m[c] = (qn[c] < 4);

    @(posedge clk);
    #1;
    if (rd[8]) chk("in_port", 32'(in_port), 32'(rd[7:0]));
    chk("interrupt", 32'(interrupt), 32'(pend_m));
    chk("ch_in_ready", 32'(ch_in_ready), 32'(ready_m));
    chk("ch_out_valid", 32'(ch_out_valid), 32'(ov_m));
    chk("ch_out_data", ch_out_data, {od_m[3], od_m[2], od_m[1], od_m[0]});
  endtask

  task automatic rd_port(input logic [7:0] p, input bit strobe);
    port_id     = p;
    read_strobe = strobe;
    tick();
    read_strobe = 1'b0;
  endtask

  task automatic wr_port(input logic [7:0] p, input logic [7:0] d);
    port_id      = p;
    out_port     = d;
    write_strobe = 1'b1;
    tick();
    write_strobe = 1'b0;
  endtask

  task automatic push(input int c, input logic [7:0] d);
    ch_in_valid          = 4'b0001 << c;
    ch_in_data[8*c +: 8] = d;
    tick();
    ch_in_valid = 4'h0;
  endtask

  initial begin
    logic [7:0] vals [5];
    reset_n       = 1'b0;
    port_id       = 8'h00;
    out_port      = 8'h00;
    write_strobe  = 1'b0;
    read_strobe   = 1'b0;
    interrupt_ack = 1'b0;
    ch_in_valid   = 4'h0;
    ch_in_data    = 32'h0;
    for (int i = 0; i < 32; i++) ram_known[i] = 1'b0;
    model_reset();

    // 1: reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_port", 32'(in_port), 32'h0);
    chk("rst_interrupt", 32'(interrupt), 32'h0);
    chk("rst_ch_out_valid", 32'(ch_out_valid), 32'h0);
    chk("rst_ch_out_data", ch_out_data, 32'h0);
    chk("rst_ch_in_ready", 32'(ch_in_ready), 32'hF);
    reset_n = 1'b1;
    tick();
    rd_port(8'h40, 1'b0);
    chk("t1_status0", 32'(in_port), 32'h01);

    // 2: FIFO order on ch1
    push(1, 8'hA5);
    push(1, 8'h3C);
    push(1, 8'h7E);
    rd_port(8'h01, 1'b1);
    chk("t2_pop0", 32'(in_port), 32'hA5);
    rd_port(8'h01, 1'b1);
    chk("t2_pop1", 32'(in_port), 32'h3C);
    rd_port(8'h01, 1'b1);
    chk("t2_pop2", 32'(in_port), 32'h7E);
    rd_port(8'h41, 1'b0);
    chk("t2_status1", 32'(in_port), 32'h01);

    // 3: fill ch0 past full
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) begin
      push(0, vals[i]);
      if (i == 3) chk("t3_ready_full", 32'(ch_in_ready[0]), 32'h0);
    end
    rd_port(8'h40, 1'b0);
    chk("t3_status_full", 32'(in_port), 32'h22);
    for (int i = 0; i < 4; i++) begin
      rd_port(8'h00, 1'b1);
      chk("t3_pop", 32'(in_port), 32'(vals[i]));
    end

    // 4: underflow on ch2
    rd_port(8'h02, 1'b1);
    chk("t4_pop_empty", 32'(in_port), 32'h00);
    rd_port(8'h42, 1'b0);
    chk("t4_status_uf", 32'(in_port), 32'h05);
    wr_port(8'h42, 8'hFF);
    rd_port(8'h42, 1'b0);
    chk("t4_status_clr", 32'(in_port), 32'h01);

    // 5: scratch RAM and aliasing
    wr_port(8'h85, 8'h9C);
    wr_port(8'h80, 8'h11);
    rd_port(8'h85, 1'b0);
    chk("t5_ram85", 32'(in_port), 32'h9C);
    rd_port(8'hA5, 1'b0);
    chk("t5_alias", 32'(in_port), 32'h9C);

    // 5b: channel output pulse
    wr_port(8'h83, 8'h77);
    chk("t5b_valid", 32'(ch_out_valid), 32'h8);
    chk("t5b_data", 32'(ch_out_data[31:24]), 32'h77);
    tick();
    chk("t5b_valid_drop", 32'(ch_out_valid), 32'h0);

    // 6: masked interrupt
    wr_port(8'hC0, 8'h02);
    rd_port(8'hC0, 1'b0);
    chk("t6_mask_read", 32'(in_port), 32'h02);
    push(0, 8'hD0);
    chk("t6_irq_masked", 32'(interrupt), 32'h0);
    push(1, 8'hD1);
    chk("t6_irq_set", 32'(interrupt), 32'h1);
    interrupt_ack = 1'b1;
    tick();
    interrupt_ack = 1'b0;
    chk("t6_irq_ack", 32'(interrupt), 32'h0);
    rd_port(8'h01, 1'b1);
    push(1, 8'hD2);
    chk("t6_irq_again", 32'(interrupt), 32'h1);
    for (int i = 0; i < 3; i++) push(0, 8'(8'hE0 + i));
    chk("t6b_full_pre", 32'(ch_in_ready[0]), 32'h0);

    // 6b: asynchronous reset mid-cycle
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6b_ready", 32'(ch_in_ready), 32'hF);
    chk("t6b_interrupt", 32'(interrupt), 32'h0);
    chk("t6b_in_port", 32'(in_port), 32'h0);
    chk("t6b_out_data", ch_out_data, 32'h0);
    model_reset();
    #1;
    reset_n = 1'b1;
    rd_port(8'h40, 1'b0);
    chk("t6b_status0", 32'(in_port), 32'h01);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      int sel;
      int mode;
      sel = $urandom_range(0, 4);
      case (sel)
        0:       port_id = 8'($urandom_range(0, 7));
        1:       port_id = 8'(8'h40 + $urandom_range(0, 7));
        2:       port_id = 8'(8'h80 + $urandom_range(0, 7));
        3:       port_id = 8'hC0;
        default: port_id = 8'($urandom);
      endcase
      mode          = $urandom_range(0, 2);
      read_strobe   = (mode == 1);
      write_strobe  = (mode == 2);
      out_port      = 8'($urandom);
      ch_in_valid   = 4'($urandom);
      ch_in_data    = 32'($urandom);
      interrupt_ack = ($urandom_range(0, 3) == 0);
      tick();
    end
    read_strobe   = 1'b0;
    write_strobe  = 1'b0;
    ch_in_valid   = 4'h0;
    interrupt_ack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
